dbg_state_dump: RTL and testbench
=================================

Name: dbg_state_dump

Overview:
- Synthesizable, parametrised successor to the bench-side PC/register/data-memory dump of the monocycle core.
- On a trigger (external or periodic) it halts the core, then streams records over a valid/ready interface:
  - one PC record,
  - NUM_REGS register records,
  - MEM_WORDS little-endian doubleword records assembled from the byte-wide data memory.
- Sits beside `monocicle`, using the spare register-file and data-memory read ports.

Parameters:
- XLEN, 64, datapath and record width.
- NUM_REGS, 32, registers dumped (1..2^REG_AW).
- REG_AW, 5, register address width.
- MEM_AW, 10, byte address width of data memory.
- MEM_BASE, 0, first byte address dumped; must be a multiple of XLEN/8.
- MEM_WORDS, 4, doublewords dumped (0 allowed).
- AUTO_PERIOD, 0, idle cycles between automatic triggers; 0 disables auto mode.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- TRIG  in  1  request a dump; sampled only in IDLE.
- PC  in  XLEN  core program counter.
- HALT  out  1  freeze request to the core.
- REG_ADDR  out  REG_AW  register read address.
- REG_DATA  in  XLEN  register read data; combinational with REG_ADDR.
- MEM_ADDR  out  MEM_AW  data-memory byte address.
- MEM_BYTE  in  8  memory read data; combinational with MEM_ADDR.
- DUMP_VALID  out  1  record valid.
- DUMP_READY  in  1  sink accepts.
- DUMP_TAG  out  2  record type: 0 = PC, 1 = REG, 2 = MEM.
- DUMP_IDX  out  16  register index or word index.
- DUMP_DATA  out  XLEN  record payload.
- DONE  out  1  one-cycle pulse at end of dump.
- OVERRUN  out  1  sticky: trigger arrived while busy.

Behaviour:
- Reset (RST=1 at edge):
  - state = IDLE.
  - All outputs 0: HALT, DUMP_VALID, DUMP_TAG, DUMP_IDX, DUMP_DATA, REG_ADDR, MEM_ADDR, DONE, OVERRUN.
  - Auto counter = 0.
  - Reset mid-dump aborts immediately; no partial record is held.
- States: IDLE, PC_OUT, REG_RD, REG_OUT, MEM_RD, MEM_OUT, FIN.
- IDLE:
  - HALT=0. Auto counter increments each cycle.
  - Trigger accepted when TRIG=1, or when AUTO_PERIOD!=0 and counter==AUTO_PERIOD-1.
  - On accept: counter cleared; go to PC_OUT, latching DUMP_DATA=PC, TAG=0, IDX=0, DUMP_VALID=1.
- HALT=1 in every non-IDLE state.
- Handshake:
  - A record transfers on a cycle with DUMP_VALID&&DUMP_READY.
  - While DUMP_VALID=1 and DUMP_READY=0, DUMP_TAG, DUMP_IDX and DUMP_DATA hold stable.
  - DUMP_VALID is 0 in REG_RD, MEM_RD and FIN.
- PC_OUT: on transfer go to REG_RD with idx=0.
- REG_RD (1 cycle):
  - REG_ADDR=idx; REG_DATA captured into DUMP_DATA.
  - Next state REG_OUT with TAG=1, IDX=idx, VALID=1.
- REG_OUT, on transfer:
  - If idx==NUM_REGS-1: go to MEM_RD with w=0, b=0, or to FIN if MEM_WORDS==0.
  - Otherwise idx+1 and go to REG_RD.
- MEM_RD (8 cycles, b=0..7):
  - MEM_ADDR = MEM_BASE+8*w+b, truncated to MEM_AW.
  - MEM_BYTE loaded into DUMP_DATA[8b+7:8b].
  - After b=7 go to MEM_OUT with TAG=2, IDX=w.
  - Byte 0 is the LSB, matching the bench display order.
- MEM_OUT, on transfer:
  - If w==MEM_WORDS-1 go to FIN.
  - Otherwise w+1, b=0, go to MEM_RD.
- FIN (1 cycle): DONE=1, HALT=1; next state IDLE, where HALT falls.
- Latency with READY held high:
  - From the accept edge to DONE: 1 + 2*NUM_REGS + 9*MEM_WORDS cycles.
  - Records per dump: 1 + NUM_REGS + MEM_WORDS.
- TRIG=1 in any non-IDLE state: ignored, and OVERRUN set to 1. OVERRUN is cleared only by RST.
- TRIG during the FIN cycle also counts as overrun.
- TRIG and an auto trigger in the same idle cycle start a single dump.
- PC is sampled only on the accept edge; later PC changes do not affect the record.

Test Plan:
- Reset and idle: hold RST 3 cycles, then TRIG=0 for 20 cycles with AUTO_PERIOD=0. Required: every output stays 0.
- Basic dump (NUM_REGS=4, MEM_WORDS=2, READY=1):
  - Stimulus: PC=0x40; regs = 0, 5, 0xA, 0xFFFF_FFFF_FFFF_FFFF; bytes 0..15 = 0x00..0x0F; one TRIG pulse.
  - Required records, in order: (0,0,0x40), (1,0,0), (1,1,5), (1,2,0xA), (1,3,all-ones), (2,0,0x0706050403020100), (2,1,0x0F0E0D0C0B0A0908).
  - DONE exactly 27 cycles after the accept edge; HALT high throughout.
- Backpressure:
  - Stimulus: same setup; DUMP_READY toggles 0/1 pseudo-randomly.
  - Required: identical record sequence; no record dropped or duplicated; fields stable while stalled.
- Overrun: pulse TRIG 3 cycles after an accepted trigger. Required: OVERRUN=1 from the next edge and the dump is unaffected. OVERRUN stays 1 after DONE until RST.
- Auto mode: AUTO_PERIOD=10, TRIG=0. Required: first dump accepted on the 10th idle cycle after reset; the next accepted 10 idle cycles after the FIN→IDLE return.
- Reset mid-dump: assert RST while in MEM_RD with b=3. Required: the next edge gives IDLE, HALT=0, DUMP_VALID=0, DONE never pulses; a fresh TRIG restarts from the PC record.

Source files
------------

// File: rtl/dbg_state_dump.sv
// Debug state dumper: halts the core on a trigger and streams PC, register-file
// and data-memory snapshot records over a valid/ready interface.
module dbg_state_dump #(
    parameter int XLEN        = 64,
    parameter int NUM_REGS    = 32,
    parameter int REG_AW      = 5,
    parameter int MEM_AW      = 10,
    parameter int MEM_BASE    = 0,
    parameter int MEM_WORDS   = 4,
    parameter int AUTO_PERIOD = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TRIG,
    input  logic [XLEN-1:0]   PC,
    output logic              HALT,
    output logic [REG_AW-1:0] REG_ADDR,
    input  logic [XLEN-1:0]   REG_DATA,
    output logic [MEM_AW-1:0] MEM_ADDR,
    input  logic [7:0]        MEM_BYTE,
    output logic              DUMP_VALID,
    input  logic              DUMP_READY,
    output logic [1:0]        DUMP_TAG,
    output logic [15:0]       DUMP_IDX,
    output logic [XLEN-1:0]   DUMP_DATA,
    output logic              DONE,
    output logic              OVERRUN
);

    localparam int BYTES = XLEN / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [1:0] TAG_PC  = 2'd0;
    localparam logic [1:0] TAG_REG = 2'd1;
    localparam logic [1:0] TAG_MEM = 2'd2;

    typedef enum logic [2:0] {
        IDLE, PC_OUT, REG_RD, REG_OUT, MEM_RD, MEM_OUT, FIN
    } state_t;

    state_t          state;
    logic [BW-1:0]   byte_sel;
    logic [15:0]     word;
    logic [31:0]     auto_cnt;

    logic xfer;
    logic auto_hit;

    assign xfer     = DUMP_VALID && DUMP_READY;
    assign auto_hit = (AUTO_PERIOD != 0) && (auto_cnt == 32'(AUTO_PERIOD - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            HALT       <= 1'b0;
            REG_ADDR   <= '0;
            MEM_ADDR   <= '0;
            DUMP_VALID <= 1'b0;
            DUMP_TAG   <= '0;
            DUMP_IDX   <= '0;
            DUMP_DATA  <= '0;
            DONE       <= 1'b0;
            OVERRUN    <= 1'b0;
            auto_cnt   <= '0;
            word       <= '0;
            byte_sel   <= '0;
        end else begin
            DONE <= 1'b0;
            if (TRIG && state != IDLE)
                OVERRUN <= 1'b1;

            case (state)
                IDLE: begin
                    HALT <= 1'b0;
                    if (TRIG || auto_hit) begin
                        auto_cnt   <= '0;
                        HALT       <= 1'b1;
                        DUMP_DATA  <= PC;
                        DUMP_TAG   <= TAG_PC;
                        DUMP_IDX   <= '0;
                        DUMP_VALID <= 1'b1;
                        state      <= PC_OUT;
                    end else begin
                        auto_cnt <= auto_cnt + 32'd1;
                    end
                end

                PC_OUT: begin
                    if (xfer) begin
                        DUMP_VALID <= 1'b0;
                        REG_ADDR   <= '0;
                        state      <= REG_RD;
                    end
                end

                // REG_ADDR already points at the register; its data is valid this cycle
                REG_RD: begin
                    DUMP_DATA  <= REG_DATA;
                    DUMP_TAG   <= TAG_REG;
                    DUMP_IDX   <= 16'(REG_ADDR);
                    DUMP_VALID <= 1'b1;
                    state      <= REG_OUT;
                end

                REG_OUT: begin
                    if (xfer) begin
                        DUMP_VALID <= 1'b0;
                        if (REG_ADDR == REG_AW'(NUM_REGS - 1)) begin
                            if (MEM_WORDS == 0) begin
                                DONE  <= 1'b1;
                                state <= FIN;
                            end else begin
                                word     <= '0;
                                byte_sel <= '0;
                                MEM_ADDR <= MEM_AW'(MEM_BASE);
                                state    <= MEM_RD;
                            end
                        end else begin
                            REG_ADDR <= REG_ADDR + 1'b1;
                            state    <= REG_RD;
                        end
                    end
                end

                // Dumped bytes are contiguous, so the address simply walks forward
                MEM_RD: begin
                    DUMP_DATA[{byte_sel, 3'b000} +: 8] <= MEM_BYTE;
                    MEM_ADDR <= MEM_ADDR + 1'b1;
                    byte_sel <= byte_sel + 1'b1;
                    if (byte_sel == BW'(BYTES - 1)) begin
                        DUMP_TAG   <= TAG_MEM;
                        DUMP_IDX   <= word;
                        DUMP_VALID <= 1'b1;
                        state      <= MEM_OUT;
                    end
                end

                MEM_OUT: begin
                    if (xfer) begin
                        DUMP_VALID <= 1'b0;
                        if (word == 16'(MEM_WORDS - 1)) begin
                            DONE  <= 1'b1;
                            state <= FIN;
                        end else begin
                            word     <= word + 16'd1;
                            byte_sel <= '0;
                            state    <= MEM_RD;
                        end
                    end
                end

                FIN: begin
                    HALT  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    HALT       <= 1'b0;
                    DUMP_VALID <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_state_dump.sv
// Bench for dbg_state_dump: table-driven basic dump, randomized dumps against a
// record-list model, backpressure, overrun, reset mid-dump and auto trigger.
module tb_dbg_state_dump;

    typedef struct {
        logic [1:0]  tag;
        logic [15:0] idx;
        logic [63:0] data;
    } rec_t;

    logic        CLK = 1'b0;
    logic        RST, TRIG, DUMP_READY;
    logic [63:0] PC;
    logic        HALT, DUMP_VALID, DONE, OVERRUN;
    logic [4:0]  REG_ADDR;
    logic [63:0] REG_DATA, DUMP_DATA;
    logic [9:0]  MEM_ADDR;
    logic [7:0]  MEM_BYTE;
    logic [1:0]  DUMP_TAG;
    logic [15:0] DUMP_IDX;

    logic        RST_a, TRIG_a, READY_a;
    logic        HALT_a, VALID_a, DONE_a, OVERRUN_a;
    logic [4:0]  REG_ADDR_a;
    logic [63:0] REG_DATA_a, DATA_a;
    logic [9:0]  MEM_ADDR_a;
    logic [7:0]  MEM_BYTE_a;
    logic [1:0]  TAG_a;
    logic [15:0] IDX_a;

    logic [63:0] rf [32];
    logic [7:0]  mem [1024];

    int   n_chk  = 0;
    int   n_fail = 0;
    rec_t exp_q[$];
    rec_t got_q[$];
    rec_t basic_tbl [7];

    always #5 CLK = ~CLK;

    assign REG_DATA   = rf[REG_ADDR];
    assign MEM_BYTE   = mem[MEM_ADDR];
    assign REG_DATA_a = rf[REG_ADDR_a];
    assign MEM_BYTE_a = mem[MEM_ADDR_a];

    dbg_state_dump #(.XLEN(64), .NUM_REGS(4), .REG_AW(5), .MEM_AW(10), .MEM_BASE(0),
                     .MEM_WORDS(2), .AUTO_PERIOD(0)) dut (
        .CLK(CLK), .RST(RST), .TRIG(TRIG), .PC(PC), .HALT(HALT),
        .REG_ADDR(REG_ADDR), .REG_DATA(REG_DATA), .MEM_ADDR(MEM_ADDR), .MEM_BYTE(MEM_BYTE),
        .DUMP_VALID(DUMP_VALID), .DUMP_READY(DUMP_READY), .DUMP_TAG(DUMP_TAG),
        .DUMP_IDX(DUMP_IDX), .DUMP_DATA(DUMP_DATA), .DONE(DONE), .OVERRUN(OVERRUN));

    dbg_state_dump #(.XLEN(64), .NUM_REGS(4), .REG_AW(5), .MEM_AW(10), .MEM_BASE(0),
                     .MEM_WORDS(2), .AUTO_PERIOD(10)) dut_a (
        .CLK(CLK), .RST(RST_a), .TRIG(TRIG_a), .PC(PC), .HALT(HALT_a),
        .REG_ADDR(REG_ADDR_a), .REG_DATA(REG_DATA_a), .MEM_ADDR(MEM_ADDR_a), .MEM_BYTE(MEM_BYTE_a),
        .DUMP_VALID(VALID_a), .DUMP_READY(READY_a), .DUMP_TAG(TAG_a),
        .DUMP_IDX(IDX_a), .DUMP_DATA(DATA_a), .DONE(DONE_a), .OVERRUN(OVERRUN_a));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected record list: PC, then each register, then little-endian doublewords
    function automatic void build_exp(input logic [63:0] pc);
        rec_t r;
        exp_q.delete();
        r.tag = 2'd0; r.idx = 16'd0; r.data = pc;
        exp_q.push_back(r);
        for (int i = 0; i < 4; i++) begin
            r.tag = 2'd1; r.idx = 16'(i); r.data = rf[i];
            exp_q.push_back(r);
        end
        for (int w = 0; w < 2; w++) begin
            r.tag = 2'd2; r.idx = 16'(w); r.data = '0;
            for (int b = 0; b < 8; b++)
                r.data = r.data + (64'(mem[8*w + b]) << (8*b));
            exp_q.push_back(r);
        end
    endfunction

    task automatic compare_records(input string name);
        check({name, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({name, "_rec"}, {46'd0, got_q[i].tag, got_q[i].idx, got_q[i].data},
                  {46'd0, exp_q[i].tag, exp_q[i].idx, exp_q[i].data});
    endtask

    task automatic do_reset();
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
    endtask

    task automatic basic_setup();
        PC = 64'h40;
        rf[0] = 64'h0; rf[1] = 64'h5; rf[2] = 64'hA; rf[3] = '1;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    endtask

    // Triggers one dump and collects transferred records. ovr_at / rst_at give the
    // cycle (relative to the accept edge) to pulse TRIG or assert RST; -1 disables.
    task automatic run_dump(input bit rnd, input int ovr_at, input int rst_at, output int done_at);
        int   cnt;
        bit   stalled;
        rec_t cur, prev;
        got_q.delete();
        done_at = -1;
        stalled = 1'b0;
        prev = '{2'd0, 16'd0, 64'd0};
        @(posedge CLK); #1;
        TRIG = 1'b1;
        DUMP_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge CLK); #1;
        TRIG = 1'b0;
        PC = {$urandom, $urandom};
        cnt = 0;
        while (cnt < 400) begin
            @(negedge CLK);
            cur = '{DUMP_TAG, DUMP_IDX, DUMP_DATA};
            if (rst_at >= 0 && cnt == rst_at + 1) begin
                check("rst_halt", 128'(HALT), 128'(0));
                check("rst_valid", 128'(DUMP_VALID), 128'(0));
                check("rst_done", 128'(DONE), 128'(0));
                return;
            end
            if (stalled) begin
                check("stall_valid", 128'(DUMP_VALID), 128'(1));
                check("stall_fields", {46'd0, cur.tag, cur.idx, cur.data},
                      {46'd0, prev.tag, prev.idx, prev.data});
            end
            if (cnt == rst_at) check("mem_addr_b3", 128'(MEM_ADDR), 128'(3));
            if (ovr_at >= 0 && cnt == ovr_at) check("ovr_before", 128'(OVERRUN), 128'(0));
            if (ovr_at >= 0 && cnt == ovr_at + 1) check("ovr_set", 128'(OVERRUN), 128'(1));
            if (HALT !== 1'b1) check("halt_busy", 128'(HALT), 128'(1));
            if (DUMP_VALID && DUMP_READY) got_q.push_back(cur);
            stalled = DUMP_VALID && !DUMP_READY;
            prev = cur;
            if (DONE) begin
                done_at = cnt;
                break;
            end
            @(posedge CLK); cnt++; #1;
            DUMP_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            TRIG = (cnt == ovr_at);
            RST  = (cnt == rst_at);
        end
        if (done_at < 0) begin
            check("done_timeout", 128'(0), 128'(1));
        end else begin
            @(posedge CLK); #1;
            @(negedge CLK);
            check("halt_after_fin", 128'(HALT), 128'(0));
        end
    endtask

    initial begin
        int d;
        bit any_done;
        basic_tbl[0] = '{2'd0, 16'd0, 64'h40};
        basic_tbl[1] = '{2'd1, 16'd0, 64'h0};
        basic_tbl[2] = '{2'd1, 16'd1, 64'h5};
        basic_tbl[3] = '{2'd1, 16'd2, 64'hA};
        basic_tbl[4] = '{2'd1, 16'd3, 64'hFFFF_FFFF_FFFF_FFFF};
        basic_tbl[5] = '{2'd2, 16'd0, 64'h0706050403020100};
        basic_tbl[6] = '{2'd2, 16'd1, 64'h0F0E0D0C0B0A0908};

        for (int i = 0; i < 32; i++) rf[i] = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        RST = 1'b1; RST_a = 1'b1; TRIG = 1'b0; TRIG_a = 1'b0;
        DUMP_READY = 1'b0; READY_a = 1'b1; PC = '0;

        // Reset held three cycles, then idle with no trigger
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            check("idle_zero", 128'(|{HALT, DUMP_VALID, DUMP_TAG, DUMP_IDX, DUMP_DATA,
                                      REG_ADDR, MEM_ADDR, DONE, OVERRUN}), 128'(0));
        end

        // Basic dump against the fixed record table
        basic_setup();
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(basic_tbl[i]);
        run_dump(1'b0, -1, -1, d);
        check("basic_latency", 128'(d), 128'(27));
        compare_records("basic");

        // Same setup under backpressure
        basic_setup();
        run_dump(1'b1, -1, -1, d);
        compare_records("backpressure");

        // Random contents, random ready
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 4; i++) rf[i] = {$urandom, $urandom};
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            PC = {$urandom, $urandom};
            build_exp(PC);
            run_dump(1'b1, -1, -1, d);
            check("rand_done_seen", 128'(d >= 0), 128'(1));
            compare_records("random");
        end

        // Overrun: trigger while busy is ignored but sticky
        basic_setup();
        build_exp(PC);
        run_dump(1'b0, 3, -1, d);
        check("ovr_latency", 128'(d), 128'(27));
        compare_records("overrun");
        check("ovr_sticky", 128'(OVERRUN), 128'(1));
        do_reset();
        @(negedge CLK);
        check("ovr_cleared", 128'(OVERRUN), 128'(0));

        // Reset during the fourth byte read of the first memory word
        basic_setup();
        run_dump(1'b0, -1, 12, d);
        @(posedge CLK); #1 RST = 1'b0;
        any_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            any_done |= DONE;
        end
        check("rst_no_done", 128'(any_done), 128'(0));
        basic_setup();
        build_exp(PC);
        run_dump(1'b0, -1, -1, d);
        check("restart_latency", 128'(d), 128'(27));
        compare_records("restart");

        // Auto trigger every 10 idle cycles; k counts edges after the last reset edge
        @(posedge CLK); #1 RST_a = 1'b0;
        for (int k = 0; k < 53; k++) begin
            @(negedge CLK);
            check("auto_halt", 128'(HALT_a), 128'((k >= 10 && k <= 37) || k >= 48));
            check("auto_done", 128'(DONE_a), 128'(k == 37));
            if (k == 10 || k == 48) begin
                check("auto_pc_valid", 128'(VALID_a), 128'(1));
                check("auto_pc_tag", 128'(TAG_a), 128'(0));
            end
            @(posedge CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
